// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, frame size, command bytes
// and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE,
        DONE,
        ERR
    } ps2_tx_state_e;

    localparam int unsigned PS2_FRAME_BITS = 11;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the PS/2 host transmitter.
interface ps2_host_tx_if;
    logic       i_start;
    logic [7:0] i_data;
    logic       o_busy;
    logic       o_done;
    logic       o_err;

    modport master (output i_start, output i_data, input o_busy, input o_done, input o_err);
    modport slave  (input i_start, input i_data, output o_busy, output o_done, output o_err);
endinterface

// File: rtl/ps2_line_filter.sv
// Synchroniser plus stability filter for one PS/2 line; strobes on accepted 1->0.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_line,
    output logic o_level,
    output logic o_fall
);
    localparam int unsigned CW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    sync_q;
    logic          level_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;

    // Idle PS/2 lines are high, so the filter resets to 1 to avoid a false edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], i_line};
            fall_q <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_q <= sync_q[1];
                fall_q  <= level_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign o_level = level_q;
    assign o_fall  = fall_q;
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clocked-out frame,
// device ACK check and timeout; drives the open-drain pins via output-enables.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned INHIBIT_US = 120,
    parameter int unsigned TIMEOUT_MS = 15,
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    ps2_host_tx_if.slave  bus,
    input  logic          i_ps2_clk,
    input  logic          i_ps2_dat,
    output logic          o_ps2_clk_oe,
    output logic          o_ps2_dat_oe
);
    localparam int unsigned US_CYC      = CLK_HZ / 1_000_000;
    localparam int unsigned INHIBIT_CYC = US_CYC * INHIBIT_US;
    localparam int unsigned TIMEOUT_CYC = (CLK_HZ / 1000) * TIMEOUT_MS;
    localparam int unsigned CNT_MAX     = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
    localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W       = 4;

    ps2_tx_state_e state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;

    logic clk_lvl, clk_fall, dat_lvl, dat_fall_unused;
    logic [9:0] frame;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .i_clk(i_clk), .i_rst(i_rst), .i_line(i_ps2_clk),
        .o_level(clk_lvl), .o_fall(clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .i_clk(i_clk), .i_rst(i_rst), .i_line(i_ps2_dat),
        .o_level(dat_lvl), .o_fall(dat_fall_unused)
    );

    // Bits presented on falls 1..10: data LSB first, parity, stop.
    assign frame = {1'b1, odd_parity(data_q), data_q};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            data_q   <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q + CNT_W'(1);
        dat_oe_d = dat_oe_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.i_start) begin
                    data_d  = bus.i_data;
                    idx_d   = '0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == CNT_W'(INHIBIT_CYC - 1)) begin
                    cnt_d    = '0;
                    dat_oe_d = 1'b1;
                    state_d  = RTS;
                end
            end
            RTS: begin
                if (cnt_q == CNT_W'(US_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (clk_fall) begin
                    cnt_d    = '0;
                    dat_oe_d = ~frame[idx_q];
                    idx_d    = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(PS2_FRAME_BITS - 2)) begin
                        state_d = ACK;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d = ERR;
                end
            end
            ACK: begin
                if (clk_fall) begin
                    cnt_d   = '0;
                    state_d = dat_lvl ? ERR : WAIT_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d = ERR;
                end
            end
            WAIT_IDLE: begin
                if (clk_lvl && dat_lvl) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d = ERR;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        if (!(state_d inside {RTS, SEND})) begin
            dat_oe_d = 1'b0;
        end
        clk_oe_d = (state_d == INHIBIT) || (state_d == RTS);
        busy_d   = state_d inside {INHIBIT, RTS, SEND, ACK, WAIT_IDLE};
        done_d   = (state_d == DONE);
        err_d    = (state_d == ERR);
    end

    assign bus.o_busy   = busy_q;
    assign bus.o_done   = done_q;
    assign bus.o_err    = err_q;
    assign o_ps2_clk_oe = clk_oe_q;
    assign o_ps2_dat_oe = dat_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a PS/2 device model and a byte scoreboard.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned CLK_HZ      = 2_000_000;
    localparam int unsigned INHIBIT_US  = 120;
    localparam int unsigned TIMEOUT_MS  = 5;
    localparam int unsigned FILTER_LEN  = 8;
    localparam int          US_CYC      = 2;
    localparam int          INHIBIT_CYC = 240;
    localparam int          TIMEOUT_CYC = 10_000;
    localparam int          HALF        = 80;   // 12.5 kHz device clock at 2 MHz

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_oe, dat_oe;
    logic bfm_clk_low = 1'b0;
    logic bfm_dat_low = 1'b0;
    logic ps2_clk, ps2_dat;

    always #250 clk = ~clk;

    assign ps2_clk = ~(clk_oe | bfm_clk_low);
    assign ps2_dat = ~(dat_oe | bfm_dat_low);

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .CLK_HZ(CLK_HZ), .INHIBIT_US(INHIBIT_US),
        .TIMEOUT_MS(TIMEOUT_MS), .FILTER_LEN(FILTER_LEN)
    ) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus),
        .i_ps2_clk(ps2_clk), .i_ps2_dat(ps2_dat),
        .o_ps2_clk_oe(clk_oe), .o_ps2_dat_oe(dat_oe)
    );

    typedef struct {
        logic [7:0] b;
        logic       par;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    logic prev_busy = 1'b0, done_busy = 1'b1, done_prev_busy = 1'b0;

    always @(negedge clk) begin
        if (bus.o_done) begin
            done_cnt++;
            done_busy      = bus.o_busy;
            done_prev_busy = prev_busy;
        end
        if (bus.o_err) err_cnt++;
        if (bus.o_done && bus.o_err) both_cnt++;
        prev_busy = bus.o_busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_cmd(input logic [7:0] b);
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_data  = b;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] b, input logic par);
        exp_t e;
        e.b   = b;
        e.par = par;
        exp_q.push_back(e);
    endtask

    // Counts inhibit cycles (clk low only) then RTS cycles (both low).
    task automatic measure_request(output int inh, output int rts);
        inh = 0;
        while (clk_oe && !dat_oe && inh < 20000) begin
            inh++;
            @(negedge clk);
        end
        rts = 0;
        while (clk_oe && dat_oe && rts < 1000) begin
            rts++;
            @(negedge clk);
        end
    endtask

    // Device model: waits for request-to-send, clocks nclk pulses, reads on rise.
    task automatic bfm_frame(input int nclk, input bit ack, output logic [9:0] bits, output bit seen);
        bits = '0;
        seen = 1'b0;
        for (int w = 0; w < 4000 && !seen; w++) begin
            if (ps2_clk && !ps2_dat) seen = 1'b1;
            else @(negedge clk);
        end
        if (seen) begin
            tick(20);
            for (int k = 1; k <= nclk; k++) begin
                bfm_clk_low = 1'b1;
                tick(HALF);
                bfm_clk_low = 1'b0;
                if (k <= 10) bits[k-1] = ps2_dat;
                if (k == 10 && ack) bfm_dat_low = 1'b1;
                if (k == 11) bfm_dat_low = 1'b0;
                tick(HALF);
            end
        end
        bfm_dat_low = 1'b0;
    endtask

    task automatic sb_compare(input string tag, input logic [9:0] bits);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_byte"}, 32'(bits[7:0]), 32'(e.b));
            check({tag, "_par"}, 32'(bits[8]), 32'(e.par));
            check({tag, "_stop"}, 32'(bits[9]), 32'd1);
        end
    endtask

    task automatic good_frame(input string tag, input logic [7:0] b, input logic par);
        int inh, rts, d0, e0;
        logic [9:0] bits;
        bit seen;
        d0 = done_cnt;
        e0 = err_cnt;
        push_exp(b, par);
        start_cmd(b);
        check({tag, "_busy_start"}, 32'(bus.o_busy), 32'd1);
        measure_request(inh, rts);
        check({tag, "_inhibit_cyc"}, 32'(inh), 32'(INHIBIT_CYC));
        check({tag, "_rts_cyc"}, 32'(rts), 32'(US_CYC));
        bfm_frame(11, 1'b1, bits, seen);
        check({tag, "_rts_seen"}, 32'(seen), 32'd1);
        tick(60);
        sb_compare(tag, bits);
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_err_pulses"}, 32'(err_cnt - e0), 32'd0);
        check({tag, "_busy_in_done"}, 32'(done_busy), 32'd0);
        check({tag, "_busy_before_done"}, 32'(done_prev_busy), 32'd1);
        check({tag, "_oe_idle"}, 32'({clk_oe, dat_oe}), 32'd0);
    endtask

    initial begin
        #(500.0 * 200_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int inh, rts, k, d0, e0;
        logic [9:0] bits;
        bit seen;

        bus.i_start = 1'b0;
        bus.i_data  = 8'h00;
        tick(5);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_pulses", 32'({bus.o_done, bus.o_err}), 32'd0);
        check("rst_oe", 32'({clk_oe, dat_oe}), 32'd0);
        rst = 1'b0;
        tick(20);

        // Basic command and parity corners.
        good_frame("leds", CMD_SET_LEDS, 1'b1);
        good_frame("zero", 8'h00, 1'b1);
        good_frame("one", 8'h01, 1'b0);

        // Device never ACKs.
        d0 = done_cnt;
        e0 = err_cnt;
        push_exp(8'h55, 1'b1);
        start_cmd(8'h55);
        measure_request(inh, rts);
        bfm_frame(11, 1'b0, bits, seen);
        check("nack_rts_seen", 32'(seen), 32'd1);
        tick(60);
        sb_compare("nack", bits);
        check("nack_err_pulses", 32'(err_cnt - e0), 32'd1);
        check("nack_done_pulses", 32'(done_cnt - d0), 32'd0);
        check("nack_oe_idle", 32'({clk_oe, dat_oe}), 32'd0);
        check("nack_busy", 32'(bus.o_busy), 32'd0);

        // Device never clocks: error exactly TIMEOUT_CYC after SEND entry.
        d0 = done_cnt;
        e0 = err_cnt;
        start_cmd(CMD_RESET);
        measure_request(inh, rts);
        check("tmo_send_dat_oe", 32'({clk_oe, dat_oe}), 32'b01);
        k = 0;
        while (!bus.o_err && k < TIMEOUT_CYC + 100) begin
            k++;
            @(negedge clk);
        end
        check("tmo_latency", 32'(k), 32'(TIMEOUT_CYC));
        check("tmo_err_level", 32'(bus.o_err), 32'd1);
        tick(2);
        check("tmo_oe_idle", 32'({clk_oe, dat_oe}), 32'd0);
        check("tmo_err_pulses", 32'(err_cnt - e0), 32'd1);
        check("tmo_done_pulses", 32'(done_cnt - d0), 32'd0);
        tick(20);

        // Second start during a frame is ignored.
        d0 = done_cnt;
        push_exp(CMD_ECHO, 1'b1);
        start_cmd(CMD_ECHO);
        measure_request(inh, rts);
        fork
            bfm_frame(11, 1'b1, bits, seen);
            begin
                tick(400);
                start_cmd(CMD_RESET);
            end
        join
        tick(60);
        sb_compare("busy_start", bits);
        check("busy_start_done", 32'(done_cnt - d0), 32'd1);
        check("busy_start_idle", 32'(bus.o_busy), 32'd0);
        tick(200);
        check("busy_start_no_new", 32'({bus.o_busy, clk_oe}), 32'd0);

        // Reset mid-frame after the fourth data bit.
        d0 = done_cnt;
        e0 = err_cnt;
        start_cmd(8'h5A);
        measure_request(inh, rts);
        bfm_frame(4, 1'b0, bits, seen);
        check("abort_low_nibble", 32'(bits[3:0]), 32'hA);
        check("abort_busy_pre", 32'(bus.o_busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_oe", 32'({clk_oe, dat_oe}), 32'd0);
        check("abort_busy", 32'(bus.o_busy), 32'd0);
        tick(50);
        check("abort_no_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        good_frame("after_abort", 8'hF4, 1'b0);

        check("done_err_exclusive", 32'(both_cnt), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
